elevator_ctrl: RTL and testbench



---
 rtl/elevator_pkg.sv | 13 +
 rtl/elevator_scan.sv | 28 ++
 rtl/elevator_ctrl.sv | 168 ++++++++++++++++
 tb/tb_elevator_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller: FSM state encoding and travel direction.
package elevator_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DOOR = 2'd2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_scan.sv
// Combinational request scan: pending calls above, below and at the car's floor.
module elevator_scan
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 5,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] to_go,
    input  logic [FLOOR_W-1:0]    floor_number,
    output logic                  above_c,
    output logic                  below_c,
    output logic                  here_c
);

    always_comb begin
        above_c = 1'b0;
        below_c = 1'b0;
        here_c  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (to_go[i]) begin
                if (FLOOR_W'(i) > floor_number) above_c = 1'b1;
                if (FLOOR_W'(i) < floor_number) below_c = 1'b1;
                if (FLOOR_W'(i) == floor_number) here_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: latches floor calls, models per-floor travel time and door dwell.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = 5,
    parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floor_number,
    output logic [NUM_FLOORS-1:0] to_go,
    output logic                  move,
    output logic                  dir,
    output logic                  door_open,
    output logic                  idle
);

    localparam int unsigned TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [TRAV_W-1:0]  TRAV_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state,      state_nxt;
    logic [FLOOR_W-1:0]      floor_nxt,  floor_step;
    logic [NUM_FLOORS-1:0]   to_go_nxt,  clr_mask;
    logic [TRAV_W-1:0]       trav_cnt,   trav_nxt;
    logic [DOOR_W-1:0]       door_cnt,   door_nxt;
    logic                    dir_nxt;
    logic                    move_nxt;
    logic                    door_open_nxt;
    logic                    idle_nxt;
    logic                    above_c, below_c, here_c;
    logic                    ahead_c, behind_c;
    logic                    req_here_c, step_hit_c;

    elevator_scan #(
        .NUM_FLOORS   (NUM_FLOORS),
        .FLOOR_W      (FLOOR_W)
    ) u_scan (
        .to_go        (to_go),
        .floor_number (floor_number),
        .above_c      (above_c),
        .below_c      (below_c),
        .here_c       (here_c)
    );

    // State register: every observable output is registered from its next value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            floor_number <= '0;
            to_go        <= '0;
            move         <= 1'b0;
            dir          <= DIR_UP;
            door_open    <= 1'b0;
            idle         <= 1'b1;
            trav_cnt     <= '0;
            door_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            floor_number <= floor_nxt;
            to_go        <= to_go_nxt;
            move         <= move_nxt;
            dir          <= dir_nxt;
            door_open    <= door_open_nxt;
            idle         <= idle_nxt;
            trav_cnt     <= trav_nxt;
            door_cnt     <= door_nxt;
        end
    end

    // Next-state, counters, request latching and registered-output precompute.
    always_comb begin
        state_nxt  = state;
        floor_nxt  = floor_number;
        dir_nxt    = dir;
        trav_nxt   = trav_cnt;
        door_nxt   = door_cnt;
        floor_step = floor_number;
        clr_mask   = '0;
        req_here_c = 1'b0;
        step_hit_c = 1'b0;

        ahead_c  = (dir == DIR_UP) ? above_c : below_c;
        behind_c = (dir == DIR_UP) ? below_c : above_c;

        // Clamp keeps the index in range even if RUN were entered with nothing ahead.
        if (dir == DIR_UP) begin
            if (floor_number != FLOOR_TOP) floor_step = floor_number + FLOOR_W'(1);
        end else begin
            if (floor_number != '0) floor_step = floor_number - FLOOR_W'(1);
        end

        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (FLOOR_W'(i) == floor_number)) req_here_c = 1'b1;
            if (to_go[i] && (FLOOR_W'(i) == floor_step)) step_hit_c = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                trav_nxt = '0;
                door_nxt = '0;
                if (here_c) begin
                    state_nxt = ST_DOOR;
                end else if (ahead_c) begin
                    state_nxt = ST_RUN;
                end else if (behind_c) begin
                    dir_nxt   = ~dir;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (trav_cnt == TRAV_LAST) begin
                    floor_nxt = floor_step;
                    trav_nxt  = '0;
                    if (step_hit_c) begin
                        state_nxt = ST_DOOR;
                        door_nxt  = '0;
                    end
                end else begin
                    trav_nxt = trav_cnt + TRAV_W'(1);
                end
            end
            ST_DOOR: begin
                trav_nxt = '0;
                // A fresh call for this floor holds the door instead of being latched.
                if (req_here_c) begin
                    door_nxt = '0;
                end else if (door_cnt == DOOR_LAST) begin
                    door_nxt = '0;
                    if (ahead_c) begin
                        state_nxt = ST_RUN;
                    end else if (behind_c) begin
                        dir_nxt   = ~dir;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    door_nxt = door_cnt + DOOR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                trav_nxt  = '0;
                door_nxt  = '0;
            end
        endcase

        // The stop bit is served on entry to DOOR and suppressed throughout DOOR.
        if (state_nxt == ST_DOOR) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (FLOOR_W'(i) == floor_nxt) clr_mask[i] = 1'b1;
            end
        end

        to_go_nxt     = (to_go | req) & ~clr_mask;
        move_nxt      = (state_nxt == ST_RUN);
        door_open_nxt = (state_nxt == ST_DOOR);
        idle_nxt      = (state_nxt == ST_IDLE) && (to_go_nxt == '0);
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: stimulus queues expected door stops, a monitor checks them.
module tb_elevator_ctrl;

    localparam int NF = 5;
    localparam int FW = 3;
    localparam int TC = 4;
    localparam int DC = 3;

    typedef struct {
        int floor;
        int dir;
        int edge_n;
        int dwell;
    } stop_t;

    logic          clock;
    logic          reset;
    logic [NF-1:0] req;
    logic [FW-1:0] floor_number;
    logic [NF-1:0] to_go;
    logic          move;
    logic          dir;
    logic          door_open;
    logic          idle;

    int    cyc;
    int    n_checks;
    int    n_errors;
    stop_t sb[$];

    elevator_ctrl #(
        .NUM_FLOORS    (NF),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .floor_number (floor_number),
        .to_go        (to_go),
        .move         (move),
        .dir          (dir),
        .door_open    (door_open),
        .idle         (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_idle(input string name);
        int waited;
        waited = 0;
        while (!(idle && !door_open) && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        chk({name, "_idle_reached"}, int'(idle && !door_open), 1);
    endtask

    task automatic push_stop(input int f, input int d, input int e, input int w);
        stop_t s;
        s.floor  = f;
        s.dir    = d;
        s.edge_n = e;
        s.dwell  = w;
        sb.push_back(s);
    endtask

    task automatic check_home(input string name);
        chk({name, "_floor"}, int'(floor_number), 0);
        chk({name, "_to_go"}, int'(to_go), 0);
        chk({name, "_move"}, int'(move), 0);
        chk({name, "_dir"}, int'(dir), 1);
        chk({name, "_door"}, int'(door_open), 0);
        chk({name, "_idle"}, int'(idle), 1);
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        reset = 1'b0;
        wait_n(2);
        check_home(name);
        reset = 1'b1;
        wait_n(1);
    endtask

    // Monitor: a door opening/closing pair is one DUT response, compared to the queue head.
    bit    in_door;
    int    open_edge, open_floor, open_dir, dwell;
    always @(negedge clock) begin
        if (!reset) begin
            in_door = 1'b0;
        end else if (door_open && !in_door) begin
            in_door    = 1'b1;
            open_edge  = cyc;
            open_floor = int'(floor_number);
            open_dir   = int'(dir);
            dwell      = 1;
            chk("open_stop_bit_cleared", int'(to_go[floor_number]), 0);
            chk("open_move_low", int'(move), 0);
        end else if (door_open && in_door) begin
            dwell++;
        end else if (!door_open && in_door) begin
            stop_t e;
            in_door = 1'b0;
            if (sb.size() == 0) begin
                chk("unexpected_stop_floor", open_floor, -1);
            end else begin
                e = sb.pop_front();
                chk("stop_floor", open_floor, e.floor);
                chk("stop_dir", open_dir, e.dir);
                chk("stop_edge", open_edge, e.edge_n);
                chk("stop_dwell", dwell, e.dwell);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        in_door  = 1'b0;
        reset    = 1'b0;
        req      = '0;

        // Reset and a quiet idle period.
        wait_n(2);
        chk("in_reset_idle", int'(idle), 1);
        reset = 1'b1;
        wait_n(20);
        check_home("quiet");

        // Single call to the top floor from floor 0.
        req = NF'(5'b10000);
        k = cyc + 1;
        push_stop(4, 1, k + 1 + 4 * TC, DC);
        wait_n(1);
        req = '0;
        chk("s2_latched", int'(to_go), 16);
        chk("s2_move_k", int'(move), 0);
        wait_n(1);
        chk("s2_move_k1", int'(move), 1);
        for (int j = 1; j <= 3; j++) begin
            wait_n(TC);
            chk("s2_step_floor", int'(floor_number), j);
            chk("s2_step_move", int'(move), 1);
        end
        wait_idle("s2");
        chk("s2_end_floor", int'(floor_number), 4);
        chk("s2_end_to_go", int'(to_go), 0);

        // Two calls ahead: intermediate stop then continue up with no gap.
        do_reset("r3");
        req = NF'(5'b10100);
        k = cyc + 1;
        push_stop(2, 1, k + 1 + 2 * TC, DC);
        push_stop(4, 1, k + 1 + 2 * TC + DC + 2 * TC, DC);
        wait_n(1);
        req = '0;
        wait_idle("s3");
        chk("s3_end_floor", int'(floor_number), 4);
        chk("s3_end_dir", int'(dir), 1);

        // Call behind the car while passing floor 3 is served after reversal.
        do_reset("r4");
        req = NF'(5'b00100);
        k = cyc + 1;
        push_stop(2, 1, k + 1 + 2 * TC, DC);
        wait_n(1);
        req = '0;
        wait_idle("s4a");
        req = NF'(5'b10000);
        k = cyc + 1;
        push_stop(4, 1, k + 1 + 2 * TC, DC);
        wait_n(1);
        req = '0;
        wait_n(5);
        chk("s4_pass_floor", int'(floor_number), 3);
        chk("s4_pass_move", int'(move), 1);
        req = NF'(5'b00010);
        push_stop(1, 0, k + 1 + 2 * TC + DC + 3 * TC, DC);
        wait_n(1);
        req = '0;
        wait_idle("s4b");
        chk("s4_end_floor", int'(floor_number), 1);
        chk("s4_end_dir", int'(dir), 0);
        chk("s4_end_to_go", int'(to_go), 0);

        // Held call at the current floor extends the dwell.
        do_reset("r5");
        req = NF'(5'b01000);
        k = cyc + 1;
        push_stop(3, 1, k + 1 + 3 * TC, DC);
        wait_n(1);
        req = '0;
        wait_idle("s5a");
        req = NF'(5'b01000);
        k = cyc + 1;
        push_stop(3, 1, k + 1, DC + 3);
        wait_n(1);
        for (int i = 1; i <= 4; i++) begin
            wait_n(1);
            chk("s5_hold_door", int'(door_open), 1);
            chk("s5_hold_to_go", int'(to_go), 0);
            chk("s5_hold_move", int'(move), 0);
        end
        req = '0;
        wait_idle("s5b");
        chk("s5_end_floor", int'(floor_number), 3);

        // Asynchronous reset between floors 1 and 2 discards pending calls.
        do_reset("r6");
        req = NF'(5'b11000);
        wait_n(1);
        req = '0;
        wait_n(6);
        chk("s6_pre_floor", int'(floor_number), 1);
        chk("s6_pre_move", int'(move), 1);
        chk("s6_pre_to_go", int'(to_go), 24);
        reset = 1'b0;
        #1;
        check_home("s6_async");
        wait_n(2);
        reset = 1'b1;
        wait_n(10);
        check_home("s6_after");

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
